// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the pipeline memory-access stage.
package arm_pipe_pkg;

   // Memory-access FSM: IDLE accepts instructions, WAIT holds a bus request.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Default bus-abort limit, in WAIT cycles.
   localparam int TIMEOUT_DEFAULT = 255;

   // Byte-enable patterns: full word, and lane 0 (shifted up for other lanes).
   localparam logic [3:0] BE_WORD  = 4'hF;
   localparam logic [3:0] BE_LANE0 = 4'b0001;

   // Byte enable for a single byte at the given lane.
   function automatic logic [3:0] lane_be(input logic [1:0] lane);
      return BE_LANE0 << lane;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
// Handshake: the master raises mem_req with mem_addr/mem_we/mem_be/mem_wdata and
// keeps all of them stable until the slave returns mem_ready=1; the transfer
// completes in the cycle where mem_req and mem_ready are both high, and mem_rdata
// is only meaningful in that cycle. mem_ready without mem_req carries no meaning.
interface mem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/byte_lane_unit.sv
// Byte-lane steering: byte enable, store-byte replication and load-byte extract.
module byte_lane_unit
   import arm_pipe_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [7:0]  store_byte,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_ext
);

   // Pure steering; the byte sits on every lane so memory picks it via be.
   always_comb begin
      be        = lane_be(lane);
      wdata_rep = {4{store_byte}};
      load_ext  = 32'h0;
      case (lane)
         2'd0:    load_ext = {24'h0, rdata[7:0]};
         2'd1:    load_ext = {24'h0, rdata[15:8]};
         2'd2:    load_ext = {24'h0, rdata[23:16]};
         default: load_ext = {24'h0, rdata[31:24]};
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access pipeline stage: retires ALU results, issues loads/stores to data
// memory with stall-until-ready, flags misaligned word accesses and aborts stuck
// bus transfers after TIMEOUT WAIT cycles.
module mem_access_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ex_valid,
   input  logic               reg_write_enable_in,
   input  logic               mem_write_enable_in,
   input  logic               mem_read_enable_in,
   input  logic               byte_access_in,
   input  logic [3:0]         rd_in,
   input  logic [31:0]        alu_result_in,
   input  logic [31:0]        store_data_in,
   output logic               stall_out,
   mem_access_ctrl_if.master  mem,
   output logic               wb_valid,
   output logic               wb_reg_write,
   output logic [3:0]         wb_rd,
   output logic [31:0]        wb_data,
   output logic               align_fault,
   output logic               bus_error,
   output state_t             fsm_state
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        r_we, r_byte, r_rw;
   logic [3:0]  r_rd;
   logic [31:0] r_alu, r_sdata;
   logic        is_mem, misalign, accept, start_mem, in_wait, done, timeout;
   logic [3:0]  lane_be_w;
   logic [31:0] lane_wdata, lane_load;

   assign fsm_state = state;
   assign is_mem    = mem_write_enable_in | mem_read_enable_in;
   assign misalign  = is_mem & ~byte_access_in & (alu_result_in[1:0] != 2'b00);
   assign accept    = (state == ST_IDLE) & ex_valid;
   assign start_mem = accept & is_mem & ~misalign;
   assign in_wait   = (state == ST_WAIT);
   assign done      = in_wait & mem.mem_ready;
   assign timeout   = in_wait & ~mem.mem_ready & (cnt == CNT_LAST);

   byte_lane_unit u_lane (
      .lane       (r_alu[1:0]),
      .rdata      (mem.mem_rdata),
      .store_byte (r_sdata[7:0]),
      .be         (lane_be_w),
      .wdata_rep  (lane_wdata),
      .load_ext   (lane_load)
   );

   // State register; async reset drops the bus request immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next state, stall and bus outputs; bus fields come from captured registers.
   always_comb begin
      state_nxt     = state;
      stall_out     = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = 32'h0;
      mem.mem_be    = 4'h0;
      mem.mem_wdata = 32'h0;
      case (state)
         ST_IDLE: begin
            stall_out = start_mem;
            if (start_mem) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            stall_out     = ~mem.mem_ready & ~timeout;
            mem.mem_req   = 1'b1;
            mem.mem_we    = r_we;
            mem.mem_addr  = {r_alu[31:2], 2'b00};
            mem.mem_be    = r_byte ? lane_be_w : BE_WORD;
            mem.mem_wdata = r_byte ? lane_wdata : r_sdata;
            if (done || timeout) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Instruction capture, timeout counter and writeback/event pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= 8'h0;
         r_we         <= 1'b0;
         r_byte       <= 1'b0;
         r_rw         <= 1'b0;
         r_rd         <= 4'h0;
         r_alu        <= 32'h0;
         r_sdata      <= 32'h0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= 4'h0;
         wb_data      <= 32'h0;
         align_fault  <= 1'b0;
         bus_error    <= 1'b0;
      end else begin
         wb_valid    <= 1'b0;
         align_fault <= 1'b0;
         bus_error   <= 1'b0;
         if (start_mem)                       cnt <= 8'h0;
         else if (in_wait && !mem.mem_ready)  cnt <= cnt + 8'h1;
         if (accept) begin
            r_we    <= mem_write_enable_in;
            r_byte  <= byte_access_in;
            r_rw    <= reg_write_enable_in;
            r_rd    <= rd_in;
            r_alu   <= alu_result_in;
            r_sdata <= store_data_in;
            if (!is_mem || misalign) begin
               wb_valid     <= 1'b1;
               wb_reg_write <= reg_write_enable_in & ~misalign;
               wb_rd        <= rd_in;
               wb_data      <= alu_result_in;
               align_fault  <= misalign;
            end
         end
         if (done) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= r_rw;
            wb_rd        <= r_rd;
            wb_data      <= r_we ? r_alu : (r_byte ? lane_load : mem.mem_rdata);
         end
         if (timeout) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= r_rd;
            wb_data      <= r_alu;
            bus_error    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed instructions with hand-computed results,
// bus checks in the driver, writeback checked by a scoreboard monitor.
module tb_mem_access_ctrl;
   import arm_pipe_pkg::*;

   localparam int TIMEOUT_TB = 4;
   localparam int EXP_W = 40;  // {rw, rd[3:0], data[31:0], chk_data, align, berr}

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0, reg_write_enable_in = 1'b0;
   logic        mem_write_enable_in = 1'b0, mem_read_enable_in = 1'b0, byte_access_in = 1'b0;
   logic [3:0]  rd_in = 4'h0;
   logic [31:0] alu_result_in = 32'h0, store_data_in = 32'h0;
   logic        stall_out, wb_valid, wb_reg_write, align_fault, bus_error;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   state_t      fsm_state;

   mem_access_ctrl_if bus ();

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   mem_access_ctrl #(.TIMEOUT(TIMEOUT_TB)) dut (
      .clk                 (clk),
      .reset               (reset),
      .ex_valid            (ex_valid),
      .reg_write_enable_in (reg_write_enable_in),
      .mem_write_enable_in (mem_write_enable_in),
      .mem_read_enable_in  (mem_read_enable_in),
      .byte_access_in      (byte_access_in),
      .rd_in               (rd_in),
      .alu_result_in       (alu_result_in),
      .store_data_in       (store_data_in),
      .stall_out           (stall_out),
      .mem                 (bus.master),
      .wb_valid            (wb_valid),
      .wb_reg_write        (wb_reg_write),
      .wb_rd               (wb_rd),
      .wb_data             (wb_data),
      .align_fault         (align_fault),
      .bus_error           (bus_error),
      .fsm_state           (fsm_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [EXP_W-1:0] mk_exp(input logic rw, input logic [3:0] rd,
                                               input logic [31:0] data, input logic chk,
                                               input logic af, input logic be);
      return {rw, rd, data, chk, af, be};
   endfunction

   // Issue one instruction, answer the bus, check bus fields and stall cycles.
   task automatic do_instr(input logic we, input logic re, input logic byt, input logic rw,
                           input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] sdata,
                           input int ready_at, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input int exp_stalls,
                           input logic [EXP_W-1:0] exp_rec);
      int   stalls;
      logic fin;
      logic waits;
      waits = (we | re) & (byt | (alu[1:0] == 2'b00));
      @(negedge clk);
      ex_valid = 1'b1; mem_write_enable_in = we; mem_read_enable_in = re;
      byte_access_in = byt; reg_write_enable_in = rw; rd_in = rd;
      alu_result_in = alu; store_data_in = sdata;
      exp_q.push_back(exp_rec);
      #1 stalls = int'(stall_out);
      @(negedge clk);
      // Unrelated instruction on the inputs while the stage is busy.
      mem_write_enable_in = 1'b0; mem_read_enable_in = 1'b0; rd_in = 4'hF;
      reg_write_enable_in = 1'b1; alu_result_in = $urandom;
      if (!waits) ex_valid = 1'b0;
      if (waits) begin
         fin = 1'b0;
         for (int w = 1; w <= TIMEOUT_TB && !fin; w++) begin
            check("wait_state", 32'(fsm_state), 32'(ST_WAIT));
            check("mem_req", 32'(bus.mem_req), 32'd1);
            check("mem_we", 32'(bus.mem_we), 32'(we));
            check("mem_addr", bus.mem_addr, exp_addr);
            check("mem_be", 32'(bus.mem_be), 32'(exp_be));
            check("mem_wdata", bus.mem_wdata, exp_wdata);
            bus.mem_ready = (w == ready_at);
            bus.mem_rdata = (w == ready_at) ? rdata : $urandom;
            #1 stalls += int'(stall_out);
            if (w == ready_at || w == TIMEOUT_TB) fin = 1'b1;
            else @(negedge clk);
         end
         @(negedge clk);
         bus.mem_ready = 1'b0;
         ex_valid = 1'b0;
      end
      check("mem_req_idle", 32'(bus.mem_req), 32'd0);
      check("idle_state", 32'(fsm_state), 32'(ST_IDLE));
      check("stall_cycles", stalls, exp_stalls);
   endtask

   // Scoreboard monitor: every retirement/event pulse must match the queue head.
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (!reset && (wb_valid || align_fault || bus_error)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {29'h0, wb_valid, align_fault, bus_error}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_reg_write", 32'(wb_reg_write), 32'(e[39]));
            check("wb_rd", 32'(wb_rd), 32'(e[38:35]));
            if (e[2]) check("wb_data", wb_data, e[34:3]);
            check("align_fault", 32'(align_fault), 32'(e[1]));
            check("bus_error", 32'(bus_error), 32'(e[0]));
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      #1;
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_stall", 32'(stall_out), 32'd0);
      check("rst_flags", {30'h0, align_fault, bus_error}, 32'h0);
      check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      check("rst_wb_data", wb_data, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // ALU op
      do_instr(0, 0, 0, 1, 4'd3, 32'h1234, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
               mk_exp(1, 4'd3, 32'h1234, 1, 0, 0));
      // Word load 0x100, ready on the third WAIT cycle
      do_instr(0, 1, 0, 1, 4'd5, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 3,
               mk_exp(1, 4'd5, 32'hDEADBEEF, 1, 0, 0));
      // Byte load 0x102, lane 2
      do_instr(0, 1, 1, 1, 4'd6, 32'h102, 32'h0, 1, 32'hAABBCCDD, 32'h100, 4'b0100, 32'h0, 1,
               mk_exp(1, 4'd6, 32'h000000BB, 1, 0, 0));
      // Byte store 0x203 of 0x5A
      do_instr(1, 0, 1, 0, 4'd0, 32'h203, 32'h1234565A, 2, 32'h0, 32'h200, 4'b1000,
               32'h5A5A5A5A, 2, mk_exp(0, 4'd0, 32'h203, 1, 0, 0));
      // Misaligned word load 0x101
      do_instr(0, 1, 0, 1, 4'd7, 32'h101, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
               mk_exp(0, 4'd7, 32'h0, 0, 1, 0));
      // mem_ready while idle has no effect
      @(negedge clk);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
      repeat (2) @(negedge clk);
      check("idle_ready_req", 32'(bus.mem_req), 32'd0);
      check("idle_ready_stall", 32'(stall_out), 32'd0);
      bus.mem_ready = 1'b0;
      // Timeout: ready never comes
      do_instr(0, 1, 0, 1, 4'd9, 32'h300, 32'h0, 0, 32'h0, 32'h300, 4'hF, 32'h0, 4,
               mk_exp(0, 4'd9, 32'h0, 0, 0, 1));
      // Store and load both set: behaves as word store
      do_instr(1, 1, 0, 1, 4'd2, 32'h40, 32'hCAFEF00D, 1, 32'h11111111, 32'h40, 4'hF,
               32'hCAFEF00D, 1, mk_exp(1, 4'd2, 32'h40, 1, 0, 0));
      // ALU op without register write
      do_instr(0, 0, 0, 0, 4'd12, 32'hFFFF0000, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
               mk_exp(0, 4'd12, 32'hFFFF0000, 1, 0, 0));
      // Byte loads on lanes 3 and 0 (zero extension)
      do_instr(0, 1, 1, 1, 4'd1, 32'h7, 32'h0, 2, 32'h80112233, 32'h4, 4'b1000, 32'h0, 2,
               mk_exp(1, 4'd1, 32'h00000080, 1, 0, 0));
      do_instr(0, 1, 1, 1, 4'd4, 32'h0, 32'h0, 1, 32'h123456FE, 32'h0, 4'b0001, 32'h0, 1,
               mk_exp(1, 4'd4, 32'h000000FE, 1, 0, 0));

      // Reset in the middle of a WAIT
      @(negedge clk);
      ex_valid = 1'b1; mem_read_enable_in = 1'b1; byte_access_in = 1'b0;
      alu_result_in = 32'h500; rd_in = 4'd8; reg_write_enable_in = 1'b1;
      @(negedge clk);
      ex_valid = 1'b0; mem_read_enable_in = 1'b0;
      check("midwait_req_before", 32'(bus.mem_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midwait_req_dropped", 32'(bus.mem_req), 32'd0);
      check("midwait_stall", 32'(stall_out), 32'd0);
      check("midwait_state", 32'(fsm_state), 32'(ST_IDLE));
      check("midwait_be", 32'(bus.mem_be), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      // Normal operation after reset
      do_instr(0, 0, 0, 1, 4'd11, 32'hA5A5A5A5, 32'h0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0,
               mk_exp(1, 4'd11, 32'hA5A5A5A5, 1, 0, 0));

      repeat (3) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before a bus abort (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes occur on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port ex_valid, input, 1 bit: the EX/MEM stage holds a valid instruction.
REQ-005 SHALL have port reg_write_enable_in, input, 1 bit: register write enable from EX/MEM.
REQ-006 SHALL have port mem_write_enable_in, input, 1 bit: store request.
REQ-007 SHALL have port mem_read_enable_in, input, 1 bit: load request.
REQ-008 SHALL have port byte_access_in, input, 1 bit: 1 = byte access, 0 = word access.
REQ-009 SHALL have port rd_in, input, 4 bits: destination register.
REQ-010 SHALL have port alu_result_in, input, 32 bits: address for memory operations, or the result otherwise.
REQ-011 SHALL have port store_data_in, input, 32 bits: store data.
REQ-012 SHALL have port stall_out, output, 1 bit: upstream holds its register while this is high.
REQ-013 SHALL have port mem_req, output, 1 bit: memory request to data memory.
REQ-014 SHALL have port mem_we, output, 1 bit: write strobe.
REQ-015 SHALL have port mem_addr, output, 32 bits: word-aligned address, with [1:0] forced to 0.
REQ-016 SHALL have port mem_be, output, 4 bits: byte enables.
REQ-017 SHALL have port mem_wdata, output, 32 bits: write data.
REQ-018 SHALL have port mem_ready, input, 1 bit: memory completes the access in this cycle.
REQ-019 SHALL have port mem_rdata, input, 32 bits: read data, valid when mem_ready is high.
REQ-020 SHALL have port wb_valid, output, 1 bit: one-cycle pulse per retired instruction, sent to MEM/WB.
REQ-021 SHALL have port wb_reg_write, output, 1 bit: register write enable sent to MEM/WB.
REQ-022 SHALL have port wb_rd, output, 4 bits: destination register sent to MEM/WB.
REQ-023 SHALL have port wb_data, output, 32 bits: writeback data.
REQ-024 SHALL have port align_fault, output, 1 bit: one-cycle pulse for a misaligned word access.
REQ-025 SHALL have port bus_error, output, 1 bit: one-cycle pulse on a timeout abort.

Function
REQ-026 SHALL implement an FSM with states IDLE and WAIT; an instruction is accepted only in IDLE with ex_valid=1.
REQ-027 Non-memory instruction accepted SHALL produce, next cycle, wb_valid=1, wb_data=alu_result_in, wb_reg_write=reg_write_enable_in, wb_rd=rd_in, with no stall (1-cycle latency).
REQ-028 A memory op is mem_write_enable_in|mem_read_enable_in; when both are set, the op SHALL be a write and the read SHALL be ignored.
REQ-029 A word op with alu_result_in[1:0]!=0 SHALL issue no request, SHALL pulse align_fault next cycle, and SHALL retire with wb_valid=1 and wb_reg_write=0; no stall.
REQ-030 An aligned memory op accepted SHALL raise stall_out combinationally in the accept cycle and SHALL enter WAIT next edge.
REQ-031 mem_req SHALL be high and mem_addr/we/be/wdata SHALL be stable during every WAIT cycle; mem_req SHALL be low in IDLE.
REQ-032 Word op SHALL drive mem_be=4'hF and mem_wdata=store_data_in.
REQ-033 Byte op SHALL drive mem_be=4'b0001<<addr[1:0] and mem_wdata={4{store_data_in[7:0]}}.
REQ-034 stall_out SHALL equal (IDLE & accepting aligned memory op) | (WAIT & !mem_ready & !timeout).
REQ-035 In WAIT with mem_ready=1, the block SHALL return to IDLE at the edge and SHALL drive wb_valid=1 next cycle, with wb_reg_write=reg_write_enable_in and wb_rd=rd_in.
REQ-036 Load wb_data SHALL be mem_rdata for a word access, or the zero-extended byte at lane addr[1:0] for a byte access; store wb_data SHALL be alu_result_in.
REQ-037 An 8-bit counter SHALL clear on WAIT entry and increment on each WAIT cycle without mem_ready.
REQ-038 When the counter reaches TIMEOUT-1 without mem_ready, the block SHALL drop mem_req next edge, pulse bus_error, retire with wb_valid=1 and wb_reg_write=0, and return to IDLE; stall_out SHALL be low in that final cycle.
REQ-039 mem_ready while in IDLE SHALL be ignored.
REQ-040 Instruction inputs during WAIT SHALL be ignored (upstream is held); the next instruction SHALL be accepted the cycle after completion.
REQ-041 wb_valid, align_fault and bus_error SHALL be low in every cycle without a retirement or event.

Reset
REQ-042 Reset SHALL asynchronously force IDLE, counter=0, and all outputs to 0, including mid-WAIT, in which case mem_req drops immediately.
REQ-043 After reset release, the first accept SHALL occur no earlier than the first rising edge.

Structure
REQ-044 The FSM state enum, the TIMEOUT default and the byte-enable/lane constants SHALL reside in shared package arm_pipe_pkg.
REQ-045 Byte-lane extract/replicate logic SHALL be one combinational sub-module, byte_lane_unit.

Verification
REQ-046 ALU op, alu_result_in=0x1234, rd_in=3, reg_write_enable_in=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, stall_out=0 throughout.
REQ-047 Word load at 0x100, mem_ready after 3 WAIT cycles with mem_rdata=0xDEADBEEF -> mem_be=F and stall_out high for 3 cycles, then wb_data=0xDEADBEEF.
REQ-048 Byte load at 0x102, mem_rdata=0xAABBCCDD, ready on first WAIT cycle -> wb_data=0x000000BB.
REQ-049 Byte store at 0x203 with data 0x5A -> mem_addr=0x200, mem_be=4'b1000, mem_wdata=0x5A5A5A5A; word load at 0x101 -> align_fault pulse, mem_req never high.
REQ-050 TIMEOUT=4, mem_ready held 0 -> mem_req high for 4 cycles, bus_error pulse, wb_reg_write=0; a reset asserted mid-WAIT drops mem_req without waiting for a clock edge.
